// File: rtl/imem_loader_ctrl.sv
// Host-side load/run/inspect sequencer: streams a program into instruction memory,
// runs the processor for a fixed window, then reads back a register range.
module imem_loader_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int REG_W      = 4,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 5,
    parameter int RUN_CYCLES = 25
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [ADDR_W-1:0] addr,
    output logic              wEn,
    output logic [DATA_W-1:0] wDat,
    output logic              working,
    output logic [REG_W-1:0]  rID,
    input  logic [DATA_W-1:0] rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [REG_W-1:0]  dump_id,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W:0]   load_count,
    output logic              busy,
    output logic              done
);

    localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_SETTLE, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                working_q, working_d;
    logic [REG_W-1:0]    rid_q, rid_d;
    logic                dump_valid_q, dump_valid_d;
    logic [REG_W-1:0]    dump_id_q, dump_id_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wen_d        = 1'b0;
        wdat_d       = wdat_q;
        rid_d        = rid_q;
        dump_id_d    = dump_id_q;
        dump_data_d  = dump_data_q;
        load_count_d = load_count_q;
        run_cnt_d    = run_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    wen_d        = 1'b1;
                    addr_d       = load_count_q[ADDR_W-1:0];
                    wdat_d       = in_data;
                    load_count_d = load_count_q + (ADDR_W+1)'(1);
                    // Top address ends the session so the write pointer never wraps.
                    if (in_last || load_count_q == LAST_ADDR)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d   = S_RUN;
                run_cnt_d = '0;
            end
            S_RUN: begin
                if (run_cnt_q == RUN_W'(RUN_CYCLES - 1)) begin
                    state_d = S_SETTLE;
                    rid_d   = REG_W'(DUMP_FIRST);
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            S_SETTLE: state_d = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                // rdata has had a full cycle to follow rID by now.
                dump_data_d = rdata;
                dump_id_d   = rid_q;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_ready) begin
                    if (rid_q == REG_W'(DUMP_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        rid_d   = rid_q + REG_W'(1);
                        state_d = S_DUMP_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d   = (state_d == S_LOAD);
        working_d    = (state_d == S_RUN);
        dump_valid_d = (state_d == S_DUMP_OUT);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdat_q       <= '0;
            working_q    <= 1'b0;
            rid_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_id_q    <= '0;
            dump_data_q  <= '0;
            load_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdat_q       <= wdat_d;
            working_q    <= working_d;
            rid_q        <= rid_d;
            dump_valid_q <= dump_valid_d;
            dump_id_q    <= dump_id_d;
            dump_data_q  <= dump_data_d;
            load_count_q <= load_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign addr       = addr_q;
    assign wEn        = wen_q;
    assign wDat       = wdat_q;
    assign working    = working_q;
    assign rID        = rid_q;
    assign dump_valid = dump_valid_q;
    assign dump_id    = dump_id_q;
    assign dump_data  = dump_data_q;
    assign load_count = load_count_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl with a write/dump scoreboard and a tiny processor model.
module tb_imem_loader_ctrl;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main DUT (defaults)
    logic        start, in_valid, in_ready, in_last, wEn, working, dump_valid, dump_ready, busy, done;
    logic [31:0] in_data, wDat, rdata, dump_data;
    logic [8:0]  addr;
    logic [3:0]  rID, dump_id;
    logic [9:0]  load_count;

    imem_loader_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .addr(addr), .wEn(wEn), .wDat(wDat),
        .working(working), .rID(rID), .rdata(rdata), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_id(dump_id), .dump_data(dump_data),
        .load_count(load_count), .busy(busy), .done(done)
    );

    // capacity DUT (16-word memory)
    logic        c_start, c_in_valid, c_in_ready, c_wEn, c_working, c_dump_valid, c_busy, c_done;
    logic [31:0] c_in_data, c_wDat, c_dump_data;
    logic [3:0]  c_addr, c_rID, c_dump_id;
    logic [4:0]  c_load_count;
    logic        c_in_last   = 1'b0;
    logic        c_dump_ready = 1'b1;
    logic [31:0] c_rdata     = 32'h0;

    imem_loader_ctrl #(.ADDR_W(4)) dut_cap (
        .clock(clock), .reset(reset), .start(c_start), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .addr(c_addr), .wEn(c_wEn), .wDat(c_wDat),
        .working(c_working), .rID(c_rID), .rdata(c_rdata), .dump_valid(c_dump_valid),
        .dump_ready(c_dump_ready), .dump_id(c_dump_id), .dump_data(c_dump_data),
        .load_count(c_load_count), .busy(c_busy), .done(c_done)
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] prog [12] = '{32'h10f00001, 32'h10f1000a, 32'h10f20014, 32'h10f3001e,
                               32'h10f40028, 32'h10f50032, 32'h41000065, 32'h41100066,
                               32'h41200067, 32'h40300065, 32'h40400066, 32'h40500067};
    logic [31:0] exp_vals [6] = '{32'd1, 32'd10, 32'd20, 32'd1, 32'd10, 32'd20};

    // Processor model: executes whatever was written to imem when working rises.
    logic [31:0] imem [512];
    logic [31:0] regs [16];
    logic [31:0] dmem [256];
    int          wr_seen, work_cycles, dumps_seen, c_wr_seen;
    logic        working_prev = 1'b0;

    assign rdata = regs[rID];

    initial for (int i = 0; i < 16; i++) regs[i] = '0;

    function automatic void run_model();
        logic [31:0] w;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        for (int i = 0; i < wr_seen; i++) begin
            w = imem[i];
            case (w[31:24])
                8'h10:   regs[w[19:16]] = 32'(w[15:0]);
                8'h41:   dmem[w[7:0]] = regs[w[23:20]];
                8'h40:   regs[w[23:20]] = dmem[w[7:0]];
                default: ;
            endcase
        end
    endfunction

    always @(negedge clock) begin
        if (working) work_cycles++;
        if (working && !working_prev) run_model();
        working_prev = working;
    end

    // Write scoreboard: accepted words queued, checked when wEn appears.
    logic [31:0] wq[$];
    always @(negedge clock) begin
        if (wEn) begin
            if (wq.size() == 0) chk("wr_unexpected", wq.size(), 1);
            else chk("wr_data", wDat, wq.pop_front());
            chk("wr_addr", addr, wr_seen);
            chk("wr_working", working, 0);
            imem[addr] = wDat;
            wr_seen++;
        end
        if (!reset && in_valid && in_ready) wq.push_back(in_data);
    end

    // Dump scoreboard: front entry must be presented (and stable) until handshake.
    logic [35:0] dq[$];
    always @(negedge clock) begin
        if (dump_valid) begin
            if (dq.size() == 0) chk("dump_unexpected", dq.size(), 1);
            else begin
                chk("dump_id", dump_id, dq[0][35:32]);
                chk("dump_data", dump_data, dq[0][31:0]);
                chk("dump_rid", rID, dq[0][35:32]);
                if (dump_ready) begin
                    void'(dq.pop_front());
                    dumps_seen++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (c_wEn) begin
            chk("cap_addr", c_addr, c_wr_seen);
            chk("cap_wdat", c_wDat, 32'hC000_0000 + c_wr_seen);
            c_wr_seen++;
        end
    end

    task automatic begin_session(input bit push);
        wr_seen = 0; work_cycles = 0; dumps_seen = 0;
        if (push) for (int i = 0; i < 6; i++) dq.push_back({4'(i), exp_vals[i]});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sess_busy", busy, 1);
        chk("sess_count_clr", load_count, 0);
        chk("sess_in_ready", in_ready, 1);
    endtask

    task automatic feed(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) begin
            bit acc = 0;
            int guard = 0;
            while (!acc && guard < 50) begin
                guard++;
                if (gaps && $urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    in_last  = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b1;
                    in_data  = prog[i];
                    in_last  = (i == 11);
                    acc      = in_ready;
                end
                tick();
            end
            chk("feed_accept", acc, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 400) begin tick(); n++; end
        chk(tag, done, 1);
    endtask

    task automatic wait_dump_valid();
        int n = 0;
        while (!dump_valid && n < 100) begin tick(); n++; end
        chk("dump_valid_wait", dump_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wEn"}, wEn, 0);
        chk({tag, "_wDat"}, wDat, 0);
        chk({tag, "_working"}, working, 0);
        chk({tag, "_rID"}, rID, 0);
        chk({tag, "_dump_valid"}, dump_valid, 0);
        chk({tag, "_dump_id"}, dump_id, 0);
        chk({tag, "_dump_data"}, dump_data, 0);
        chk({tag, "_load_count"}, load_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int acc, n;
        bit fell_checked;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; dump_ready = 1'b0;
        c_start = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_wr_seen = 0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // nominal program, no backpressure
        dump_ready = 1'b1;
        begin_session(1);
        feed(0, 12, 0);
        wait_done("nom_done");
        chk("nom_load_count", load_count, 12);
        chk("nom_writes", wr_seen, 12);
        chk("nom_run_cycles", work_cycles, 25);
        chk("nom_dumps", dumps_seen, 6);
        chk("nom_busy", busy, 0);
        chk("nom_working", working, 0);

        // input gaps + dump backpressure
        dump_ready = 1'b0;
        begin_session(1);
        feed(0, 12, 1);
        for (int d = 0; d < 6; d++) begin
            wait_dump_valid();
            repeat (7) tick();
            dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
        end
        wait_done("bp_done");
        chk("bp_writes", wr_seen, 12);
        chk("bp_dumps", dumps_seen, 6);
        chk("bp_run_cycles", work_cycles, 25);

        // reset during the 10th run cycle
        dump_ready = 1'b1;
        begin_session(0);
        feed(0, 12, 0);
        n = 0;
        while (!working && n < 20) begin tick(); n++; end
        repeat (9) tick();
        chk("rst_run_working", working, 1);
        reset = 1'b1;
        tick();
        check_zero("rst_run");
        reset = 1'b0;
        tick();

        // start ignored in LOAD and DUMP_OUT, honoured in DONE
        dump_ready = 1'b0;
        begin_session(1);
        feed(0, 5, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_load_count", load_count, 5);
        chk("start_in_load_busy", busy, 1);
        feed(5, 12, 0);
        wait_dump_valid();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_dump_valid", dump_valid, 1);
        chk("start_in_dump_busy", busy, 1);
        dump_ready = 1'b1;
        wait_done("restart_done");
        chk("restart_writes", wr_seen, 12);
        chk("restart_dumps", dumps_seen, 6);
        chk("restart_load_count", load_count, 12);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_done", done, 0);
        chk("done_start_busy", busy, 1);
        chk("done_start_count", load_count, 0);
        chk("done_start_ready", in_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // capacity: 20 words offered to a 16-word memory, no in_last
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        acc = 0;
        fell_checked = 0;
        for (int k = 0; k < 20; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = 32'hC000_0000 + acc;
            if (c_in_ready) acc++;
            tick();
            if (acc == 16 && !fell_checked) begin
                chk("cap_ready_fall", c_in_ready, 0);
                fell_checked = 1;
            end
        end
        c_in_valid = 1'b0;
        chk("cap_accepted", acc, 16);
        chk("cap_writes", c_wr_seen, 16);
        chk("cap_load_count", c_load_count, 16);
        n = 0;
        while (!c_working && n < 20) begin tick(); n++; end
        chk("cap_run", c_working, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
